serializer_gearbox: RTL and testbench
=====================================

Name: serializer_gearbox

Overview:
- Parametrised soft successor to the fixed 10:1 primitive-based serializer: multi-lane N:1 gearbox in the fast-clock domain.
- Emits BITS_PER_CLK bits per lane per cycle, typically feeding a DDR output register pair.
- Accepts parallel words over a valid/ready handshake into a one-word hold buffer.
- On starvation, auto-inserts a configurable idle word (TMDS control token) and counts underflows.
- Sits between the TMDS encoders and the IO registers of the display output path.

Parameters:
- WIDTH, 10, parallel word width per lane; must be a multiple of BITS_PER_CLK.
- CHANNELS, 3, number of lanes, all sharing one handshake.
- BITS_PER_CLK, 2, bits emitted per lane per i_clk cycle (1 = SDR, 2 = DDR pair).
- LSB_FIRST, 1, 1 = word bit 0 transmitted first; 0 = bit WIDTH-1 first.
- IDLE_WORD, 10'b1101010100, word substituted on every lane on underflow.

Ports:
- i_clk  input  1  fast clock (parallel word rate × WIDTH/BITS_PER_CLK)
- i_rst  input  1  synchronous reset, active high
- i_valid  input  1  i_data holds a word for all lanes
- o_ready  output  1  hold buffer can accept this cycle
- i_data  input  CHANNELS*WIDTH  lane c = [c*WIDTH +: WIDTH]
- o_data  output  CHANNELS*BITS_PER_CLK  lane c = [c*B +: B]; bit [c*B+0] is earliest in time
- o_word_start  output  1  high on the cycle o_data carries the first beat of a word
- o_underflow_cnt  output  16  saturating count of idle words inserted

Behaviour:
- BEATS = WIDTH/BITS_PER_CLK. A beat counter runs 0..BEATS-1 and wraps. Shift register per lane; hold register shared with flag hold_full (FSM states EMPTY/FULL).
- Accept: i_valid && o_ready. o_ready = !hold_full || load_now, where load_now = (beat == BEATS-1). Combinational from registered state only; no dependency on i_valid.
- load_now: each lane shift register loads hold data if hold_full, else IDLE_WORD; o_underflow_cnt increments (saturates at 16'hFFFF).
- Hold flag updates:
  - Accept and load_now in the same cycle: hold is refilled, stays FULL.
  - load_now with no accept: hold becomes EMPTY.
  - Accept with hold EMPTY (not load_now): hold becomes FULL.
  - No bypass: a word accepted into an empty hold waits for the next load_now.
- Other beats: shift by BITS_PER_CLK toward the transmit end (LSB side if LSB_FIRST, else MSB side).
- o_data and o_word_start are registered. The first beat appears the cycle after load_now. Latency from accept to first beat is 1..BEATS+1 cycles.
- Bit mapping, WIDTH=10, B=2, LSB_FIRST=1: beat k of lane c carries word bits {2k+1, 2k} on o_data[c*2+1], o_data[c*2+0].
- Reset (also mid-word):
  - beat = BEATS-1, hold EMPTY, shift registers = IDLE_WORD.
  - o_data = 0, o_word_start = 0, o_underflow_cnt = 0, o_ready = 0 while i_rst is high.
  - The partial word and held word are discarded.
  - The first cycle after reset is load_now: it loads IDLE and counts 1 underflow.

Optional Feature:
- Macro: SERIALIZER_GEARBOX_PRBS_EN.
- With the macro defined:
  - Adds input i_prbs_en (1 bit).
  - While high, each lane's shift register loads a PRBS7 word (x^7+x^6+1, per-lane seed = 7'h01 + c, advanced WIDTH steps per word) at load_now, instead of hold/idle data.
  - Hold buffer and handshake keep operating; underflow count is frozen.
- Without the macro: port absent, no LFSR logic.

Decomposition:
- serializer_pkg:
  - TMDS control token constants (CTRL_00..CTRL_11).
  - Function beats(width, bpc).
  - PRBS7 step function.
- Sub-module serializer_lane (one shift register, load mux, bit ordering), instantiated CHANNELS times.
- Beat counter, hold FSM and underflow counter live in the top.

Test Plan:
- Defaults, single word 10'b1111100000 on all lanes, LSB_FIRST=1 → lane beats 00,00,10,11,11; o_word_start high on the 00 beat only.
- Continuous i_valid=1 for 20 words with incrementing data → no idle words; o_underflow_cnt stays at 1 (post-reset load); o_ready low exactly when hold FULL and not load_now.
- i_valid=0 for 3 word periods → 3 IDLE_WORD frames emitted (beats 00,01,01,01,11 per lane); count increments by 3.
- i_rst asserted on beat 2 of a word → next cycle o_data=0, hold EMPTY; after release, IDLE emitted; first accepted word appears intact.
- LSB_FIRST=0, BITS_PER_CLK=1, word 10'b1000000001 → serial stream 1,0,0,0,0,0,0,0,0,1.
- PRBS_EN build, i_prbs_en=1 → lane 0 stream matches PRBS7 reference from seed 7'h01; lanes differ.

Source files
------------

// File: rtl/serializer_gearbox_pkg.sv
// rtl/serializer_gearbox_pkg.sv - shared constants, types and helpers for the serializer gearbox (optional PRBS: SERIALIZER_GEARBOX_PRBS_EN)
package serializer_gearbox_pkg;

    // TMDS control tokens; CTRL_00 is the usual idle filler
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    function automatic int beats(input int width, input int bpc);
        return width / bpc;
    endfunction

    // One step of x^7 + x^6 + 1; the new bit enters at bit 0 and is the output bit
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/serializer_gearbox_if.sv
// rtl/serializer_gearbox_if.sv - parallel word handshake shared by all lanes
interface serializer_gearbox_if #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 10
);
    logic                      i_valid;
    logic                      o_ready;
    logic [CHANNELS*WIDTH-1:0] i_data;

    modport master (output i_valid, output i_data, input o_ready);
    modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/serializer_gearbox_lane.sv
// rtl/serializer_gearbox_lane.sv - one lane: load mux, shift register and bit ordering (optional PRBS: SERIALIZER_GEARBOX_PRBS_EN)
module serializer_gearbox_lane
    import serializer_gearbox_pkg::*;
#(
    parameter int               WIDTH        = 10,
    parameter int               BITS_PER_CLK = 2,
    parameter int               LSB_FIRST    = 1,
    parameter int               LANE         = 0,
    parameter logic [WIDTH-1:0] IDLE_WORD    = WIDTH'(CTRL_00)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_word,
`ifdef SERIALIZER_GEARBOX_PRBS_EN
    input  logic                    prbs_en,
`endif
    output logic [BITS_PER_CLK-1:0] data
);

    // shreg holds only the bits not yet sent; data is the beat currently on the wire
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_sel;

    // Earliest-in-time bit of a beat always lands on data[0]
    function automatic logic [BITS_PER_CLK-1:0] front(input logic [WIDTH-1:0] w);
        logic [BITS_PER_CLK-1:0] f;
        for (int j = 0; j < BITS_PER_CLK; j++)
            f[j] = (LSB_FIRST != 0) ? w[j] : w[WIDTH-1-j];
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> BITS_PER_CLK) : (w << BITS_PER_CLK);
    endfunction

`ifdef SERIALIZER_GEARBOX_PRBS_EN
    logic [6:0]       lfsr;
    logic [6:0]       lfsr_next;
    logic [WIDTH-1:0] prbs_word;

    // Generate a whole word of PRBS7; word bit i is the i-th generated bit
    always_comb begin
        lfsr_next = lfsr;
        prbs_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lfsr_next    = prbs7_step(lfsr_next);
            prbs_word[i] = lfsr_next[0];
        end
    end

    // Generator only advances when its word is actually loaded
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 7'(7'h01 + LANE);
        else if (load && prbs_en)
            lfsr <= lfsr_next;
    end

    assign word_sel = prbs_en ? prbs_word : load_word;
`else
    assign word_sel = load_word;
`endif

    // Load a fresh word on the last beat, otherwise shift toward the transmit end
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= IDLE_WORD;
            data  <= '0;
        end else if (load) begin
            shreg <= advance(word_sel);
            data  <= front(word_sel);
        end else begin
            shreg <= advance(shreg);
            data  <= front(shreg);
        end
    end

endmodule

// File: rtl/serializer_gearbox.sv
// rtl/serializer_gearbox.sv - multi-lane N:1 gearbox with hold buffer and idle insertion (optional PRBS: SERIALIZER_GEARBOX_PRBS_EN)
module serializer_gearbox
    import serializer_gearbox_pkg::*;
#(
    parameter int               WIDTH        = 10,
    parameter int               CHANNELS     = 3,
    parameter int               BITS_PER_CLK = 2,
    parameter int               LSB_FIRST    = 1,
    parameter logic [WIDTH-1:0] IDLE_WORD    = WIDTH'(CTRL_00)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    serializer_gearbox_if.slave              s_in,
`ifdef SERIALIZER_GEARBOX_PRBS_EN
    input  logic                             i_prbs_en,
`endif
    output logic [CHANNELS*BITS_PER_CLK-1:0] o_data,
    output logic                             o_word_start,
    output logic [15:0]                      o_underflow_cnt
);

    localparam int BEATS = beats(WIDTH, BITS_PER_CLK);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    hold_state_t               state;
    hold_state_t               state_next;
    logic [BW-1:0]             beat;
    logic [CHANNELS*WIDTH-1:0] hold_data;
    logic                      load_now;
    logic                      ready;
    logic                      accept;
    logic                      prbs_active;

    assign load_now    = (beat == BW'(BEATS-1));
    assign s_in.o_ready = ready;

`ifdef SERIALIZER_GEARBOX_PRBS_EN
    assign prbs_active = i_prbs_en;
`else
    assign prbs_active = 1'b0;
`endif

    // Hold flag register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= HOLD_EMPTY;
        else
            state <= state_next;
    end

    // Ready depends only on registered state; a word in an empty hold waits for the next load
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        accept     = 1'b0;
        if (!i_rst)
            ready = (state == HOLD_EMPTY) || load_now;
        accept = s_in.i_valid && ready;
        if (accept)
            state_next = HOLD_FULL;
        else if (load_now)
            state_next = HOLD_EMPTY;
    end

    // Hold buffer capture; contents only matter while the flag says FULL
    always_ff @(posedge i_clk) begin
        if (accept)
            hold_data <= s_in.i_data;
    end

    // Beat counter; reset parks it on the last beat so the first cycle out of reset loads
    always_ff @(posedge i_clk) begin
        if (i_rst)
            beat <= BW'(BEATS-1);
        else if (load_now)
            beat <= '0;
        else
            beat <= beat + BW'(1);
    end

    // Word start marks the beat right after a load
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_word_start <= 1'b0;
        else
            o_word_start <= load_now;
    end

    // Saturating count of loads that fell back to the idle token
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_underflow_cnt <= '0;
        else if (load_now && state == HOLD_EMPTY && !prbs_active && o_underflow_cnt != 16'hFFFF)
            o_underflow_cnt <= o_underflow_cnt + 16'd1;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [WIDTH-1:0] lane_word;
        assign lane_word = (state == HOLD_FULL) ? hold_data[c*WIDTH +: WIDTH] : IDLE_WORD;

        serializer_gearbox_lane #(
            .WIDTH        (WIDTH),
            .BITS_PER_CLK (BITS_PER_CLK),
            .LSB_FIRST    (LSB_FIRST),
            .LANE         (c),
            .IDLE_WORD    (IDLE_WORD)
        ) u_lane (
            .clk       (i_clk),
            .rst       (i_rst),
            .load      (load_now),
            .load_word (lane_word),
`ifdef SERIALIZER_GEARBOX_PRBS_EN
            .prbs_en   (i_prbs_en),
`endif
            .data      (o_data[c*BITS_PER_CLK +: BITS_PER_CLK])
        );
    end

endmodule

// File: tb/tb_serializer_gearbox.sv
// tb/tb_serializer_gearbox.sv - directed self-checking bench for serializer_gearbox (optional PRBS: SERIALIZER_GEARBOX_PRBS_EN)
`timescale 1ns/1ps
module tb_serializer_gearbox;

    localparam logic [9:0] IDLE = 10'b1101010100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serializer_gearbox_if #(.CHANNELS(3), .WIDTH(10)) bus ();
    serializer_gearbox_if #(.CHANNELS(1), .WIDTH(10)) bus2 ();

    logic [5:0]  data;
    logic        ws;
    logic [15:0] ucnt;
    logic [0:0]  data2;
    logic        ws2;
    logic [15:0] ucnt2;
`ifdef SERIALIZER_GEARBOX_PRBS_EN
    logic        prbs_en = 1'b0;
    logic        prbs_en2 = 1'b0;
`endif

    serializer_gearbox #(
        .WIDTH(10), .CHANNELS(3), .BITS_PER_CLK(2), .LSB_FIRST(1), .IDLE_WORD(IDLE)
    ) dut (
        .i_clk(clk), .i_rst(rst), .s_in(bus),
`ifdef SERIALIZER_GEARBOX_PRBS_EN
        .i_prbs_en(prbs_en),
`endif
        .o_data(data), .o_word_start(ws), .o_underflow_cnt(ucnt)
    );

    serializer_gearbox #(
        .WIDTH(10), .CHANNELS(1), .BITS_PER_CLK(1), .LSB_FIRST(0), .IDLE_WORD(IDLE)
    ) dut2 (
        .i_clk(clk), .i_rst(rst2), .s_in(bus2),
`ifdef SERIALIZER_GEARBOX_PRBS_EN
        .i_prbs_en(prbs_en2),
`endif
        .o_data(data2), .o_word_start(ws2), .o_underflow_cnt(ucnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] mk_word(input int i);
        return {10'(i*41 + 607), 10'(i*41 + 307), 10'(i*41 + 7)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one word on dut and return the cycle at which it was taken
    task automatic send(input logic [29:0] d, output int acc_cyc);
        bit done = 0;
        acc_cyc = -1;
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            #1;
            if (bus.o_ready) done = 1;
            @(posedge clk);
            #1;
            if (done) acc_cyc = cyc;
        end
        bus.i_valid = 1'b0;
        check("send_accept", 32'(done), 32'd1);
    endtask

    task automatic send2(input logic [9:0] d);
        bit done = 0;
        bus2.i_data  = d;
        bus2.i_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            #1;
            if (bus2.o_ready) done = 1;
            @(posedge clk);
            #1;
        end
        bus2.i_valid = 1'b0;
        check("send2_accept", 32'(done), 32'd1);
    endtask

    // Find the next word start on dut and rebuild all three lane words from its beats
    task automatic get_frame(output logic [29:0] word, output int ws_n, output logic [15:0] cnt0);
        bit found = 0;
        word = '0;
        ws_n = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (ws) found = 1;
        end
        check("frame_found", 32'(found), 32'd1);
        cnt0 = ucnt;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            ws_n += int'(ws);
            for (int c = 0; c < 3; c++)
                word[c*10 + 2*k +: 2] = data[c*2 +: 2];
        end
    endtask

    // Serial stream of dut2 in time order, first bit ends up in bit 9
    task automatic get_frame2(output logic [9:0] s);
        bit found = 0;
        s = '0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (ws2) found = 1;
        end
        check("frame2_found", 32'(found), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            s = {s[8:0], data2[0]};
        end
    endtask

    initial begin
        logic [29:0] w;
        logic [15:0] c0;
        logic [9:0]  s;
        int          wsn;
        int          acc;
        int          prev_acc;
        bit          found;
        logic [1:0]  t1_beats [5];

        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus2.i_valid = 1'b0;
        bus2.i_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data), 32'd0);
        check("rst_ws", 32'(ws), 32'd0);
        check("rst_ucnt", 32'(ucnt), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.o_ready), 32'd1);

        // Single word 1111100000 on all lanes
        t1_beats = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11};
        send({3{10'b1111100000}}, acc);
        get_frame(w, wsn, c0);
        check("t1_idle_frame", 32'(w), 32'({3{IDLE}}));
        check("t1_post_rst_ucnt", 32'(c0), 32'd1);
        get_frame(w, wsn, c0);
        for (int k = 0; k < 5; k++)
            check($sformatf("t1_beat%0d", k), 32'(w[2*k +: 2]), 32'(t1_beats[k]));
        check("t1_all_lanes", 32'(w), 32'({3{10'b1111100000}}));
        check("t1_ws_once", 32'(wsn), 32'd1);

        // Continuous stream of 20 words right after reset
        do_reset();
        fork
            begin
                prev_acc = 0;
                for (int i = 0; i < 20; i++) begin
                    send(mk_word(i), acc);
                    bus.i_valid = 1'b1;
                    if (i >= 2)
                        check($sformatf("t2_interval%0d", i), 32'(acc - prev_acc), 32'd5);
                    prev_acc = acc;
                end
                bus.i_valid = 1'b0;
            end
            begin
                get_frame(w, wsn, c0);
                check("t2_first_idle", 32'(w), 32'({3{IDLE}}));
                for (int i = 0; i < 20; i++) begin
                    get_frame(w, wsn, c0);
                    check($sformatf("t2_word%0d", i), 32'(w), 32'(mk_word(i)));
                    check($sformatf("t2_ws%0d", i), 32'(wsn), 32'd1);
                    if (i == 19) check("t2_ucnt", 32'(c0), 32'd1);
                end
            end
        join

        // Starvation: three idle frames, counter advances per frame
        for (int f = 0; f < 3; f++) begin
            get_frame(w, wsn, c0);
            check($sformatf("t3_idle%0d", f), 32'(w), 32'({3{IDLE}}));
            check($sformatf("t3_ucnt%0d", f), 32'(c0), 32'(2 + f));
        end

        // Reset on beat 2 with a second word sitting in the hold buffer
        send({3{10'b0000011111}}, acc);
        send({3{10'b1010101010}}, acc);
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (ws) found = 1;
        end
        check("t4_start_found", 32'(found), 32'd1);
        check("t4_beat0", 32'(data), 32'({3{2'b11}}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_data", 32'(data), 32'd0);
        check("t4_rst_ws", 32'(ws), 32'd0);
        check("t4_rst_ready", 32'(bus.o_ready), 32'd0);
        check("t4_rst_ucnt", 32'(ucnt), 32'd0);
        rst = 1'b0;
        send({3{10'b0110011001}}, acc);
        get_frame(w, wsn, c0);
        check("t4_idle_after_rst", 32'(w), 32'({3{IDLE}}));
        get_frame(w, wsn, c0);
        check("t4_word_intact", 32'(w), 32'({3{10'b0110011001}}));
        check("t4_ucnt", 32'(c0), 32'd1);

        // MSB-first, one bit per clock
        @(negedge clk);
        rst2 = 1'b0;
        send2(10'b1000000001);
        send2(10'b1100000010);
        get_frame2(s);
        check("t5_stream_a", 32'(s), 32'(10'b1000000001));
        check("t5_ucnt", 32'(ucnt2), 32'd1);
        get_frame2(s);
        check("t5_stream_b", 32'(s), 32'(10'b1100000010));

`ifdef SERIALIZER_GEARBOX_PRBS_EN
        begin
            logic [6:0] r;
            logic [9:0] ref_w;
            prbs_en = 1'b1;
            do_reset();
            r = 7'h01;
            for (int f = 0; f < 2; f++) begin
                for (int i = 0; i < 10; i++) begin
                    r = {r[5:0], r[6] ^ r[5]};
                    ref_w[i] = r[0];
                end
                get_frame(w, wsn, c0);
                check($sformatf("t6_prbs_lane0_%0d", f), 32'(w[9:0]), 32'(ref_w));
                check($sformatf("t6_lanes_differ_%0d", f), 32'(w[9:0] != w[19:10]), 32'd1);
                check($sformatf("t6_ucnt_frozen_%0d", f), 32'(c0), 32'd0);
            end
            prbs_en = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
